// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of the 8-bit ALU: accepts a command, drives the ALU for a
// programmable settle time, captures the result and returns it with zero/error flags.
module alu_cmd_sequencer #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned OP_W          = 3,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [OP_W-1:0]   cmd_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_enable,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  done_count,
  output logic [CNT_W-1:0]  err_count
);

  typedef enum logic [1:0] {StIdle, StDrive, StResp} state_e;

  localparam logic [OP_W-1:0] OpDiv      = OP_W'(3);
  localparam logic [OP_W-1:0] OpRsvd     = OP_W'(7);
  localparam logic [3:0]      SettleInit = 4'(SETTLE_CYCLES);

  state_e              state_q, state_d;
  logic [3:0]          settle_q, settle_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d, rsp_data_q, rsp_data_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;
  logic                alu_enable_q, alu_enable_d;
  logic                rsp_valid_q, rsp_valid_d, rsp_zero_q, rsp_zero_d, rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]    done_count_q, done_count_d, err_count_q, err_count_d;
  logic                cmd_illegal;

  // Screened commands never reach the ALU enable.
  assign cmd_illegal = (cmd_op == OpRsvd) || ((cmd_op == OpDiv) && (cmd_b == '0));

  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    alu_enable_d = alu_enable_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    done_count_d = done_count_q;
    err_count_d  = err_count_q;
    cmd_ready    = (state_q == StIdle);

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          alu_a_d  = cmd_a;
          alu_b_d  = cmd_b;
          alu_op_d = cmd_op;
          if (cmd_illegal) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
            rsp_zero_d  = 1'b0;
            err_count_d = err_count_q + CNT_W'(1);
          end else begin
            state_d      = StDrive;
            alu_enable_d = 1'b1;
            settle_d     = SettleInit;
          end
        end
      end
      StDrive: begin
        settle_d = settle_q - 4'd1;
        if (settle_q == 4'd1) begin
          state_d      = StResp;
          rsp_data_d   = alu_result;
          rsp_zero_d   = (alu_result == '0);
          rsp_err_d    = 1'b0;
          rsp_valid_d  = 1'b1;
          alu_enable_d = 1'b0;
          done_count_d = done_count_q + CNT_W'(1);
        end
      end
      StResp: begin
        // Data and flags stay as last captured after the handshake.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      settle_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      alu_enable_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      done_count_q <= '0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      alu_enable_q <= alu_enable_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
      done_count_q <= done_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign alu_enable = alu_enable_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;
  assign done_count = done_count_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: two instances (settle 1 and 4) driven by directed and random
// commands, checked against an arithmetic reference model.
module tb_alu_cmd_sequencer;

  logic       clk;
  logic       rst        [2];
  logic       cmd_valid  [2];
  logic       cmd_ready  [2];
  logic [7:0] cmd_a      [2];
  logic [7:0] cmd_b      [2];
  logic [2:0] cmd_op     [2];
  logic [7:0] alu_a      [2];
  logic [7:0] alu_b      [2];
  logic [2:0] alu_op     [2];
  logic       alu_enable [2];
  logic [7:0] alu_result [2];
  logic       rsp_valid  [2];
  logic       rsp_ready  [2];
  logic [7:0] rsp_data   [2];
  logic       rsp_zero   [2];
  logic       rsp_err    [2];
  logic [15:0] done_count [2];
  logic [15:0] err_count  [2];

  int passed = 0;
  int total  = 0;
  int done_m [2];
  int err_m  [2];

  alu_cmd_sequencer #(.DATA_W(8), .OP_W(3), .SETTLE_CYCLES(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_op(cmd_op[0]), .alu_a(alu_a[0]),
    .alu_b(alu_b[0]), .alu_op(alu_op[0]), .alu_enable(alu_enable[0]),
    .alu_result(alu_result[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_data(rsp_data[0]), .rsp_zero(rsp_zero[0]), .rsp_err(rsp_err[0]),
    .done_count(done_count[0]), .err_count(err_count[0])
  );

  alu_cmd_sequencer #(.DATA_W(8), .OP_W(3), .SETTLE_CYCLES(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_op(cmd_op[1]), .alu_a(alu_a[1]),
    .alu_b(alu_b[1]), .alu_op(alu_op[1]), .alu_enable(alu_enable[1]),
    .alu_result(alu_result[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_data(rsp_data[1]), .rsp_zero(rsp_zero[1]), .rsp_err(rsp_err[1]),
    .done_count(done_count[1]), .err_count(err_count[1])
  );

  // Stand-in for the ALU: purely combinational from the sequencer's operand outputs.
  function automatic logic [7:0] alu_stub(logic [7:0] a, logic [7:0] b, logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a * b;
      3'd3:    return (b == 8'd0) ? 8'd0 : a / b;
      3'd4:    return a & b;
      3'd5:    return a | b;
      3'd6:    return a ^ b;
      default: return 8'd0;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < 2; i++) alu_result[i] = alu_stub(alu_a[i], alu_b[i], alu_op[i]);
  end

  // Reference result computed with integer arithmetic and modulo-256 truncation.
  function automatic logic [7:0] ref_result(logic [7:0] a, logic [7:0] b, logic [2:0] op);
    int x, y, r;
    x = int'(a);
    y = int'(b);
    case (op)
      3'd0:    r = (x + y) % 256;
      3'd1:    r = (x - y + 256) % 256;
      3'd2:    r = (x * y) % 256;
      3'd3:    r = x / y;
      3'd4:    r = x & y;
      3'd5:    r = x | y;
      3'd6:    r = x ^ y;
      default: r = 0;
    endcase
    return 8'(r);
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic check_counts(int idx);
    check("done_count", 32'(done_count[idx]), 32'(done_m[idx] % 65536));
    check("err_count", 32'(err_count[idx]), 32'(err_m[idx] % 65536));
  endtask

  // One full transaction; optionally leaves cmd_valid high with a follow-up command.
  task automatic do_cmd(int idx, logic [7:0] a, logic [7:0] b, logic [2:0] op, int delay,
                        bit hold, logic [7:0] na, logic [7:0] nb, logic [2:0] nop);
    bit         bad;
    logic [7:0] exp;
    int         settle, n, en;
    settle = (idx == 0) ? 1 : 4;
    bad    = (op == 3'd7) || (op == 3'd3 && b == 8'd0);
    exp    = bad ? 8'd0 : ref_result(a, b, op);
    cmd_a[idx]     = a;
    cmd_b[idx]     = b;
    cmd_op[idx]    = op;
    cmd_valid[idx] = 1'b1;
    check("ready_before_accept", 32'(cmd_ready[idx]), 32'd1);
    tick();
    if (hold) begin
      cmd_a[idx]  = na;
      cmd_b[idx]  = nb;
      cmd_op[idx] = nop;
    end else begin
      cmd_valid[idx] = 1'b0;
    end
    check("alu_a_latched", 32'(alu_a[idx]), 32'(a));
    check("alu_b_latched", 32'(alu_b[idx]), 32'(b));
    check("alu_op_latched", 32'(alu_op[idx]), 32'(op));
    n  = 0;
    en = 0;
    while (!rsp_valid[idx] && n < 40) begin
      if (alu_enable[idx]) en++;
      check("ready_low_busy", 32'(cmd_ready[idx]), 32'd0);
      tick();
      n++;
    end
    if (bad) err_m[idx]++;
    else done_m[idx]++;
    check("rsp_latency", 32'(n), bad ? 32'd0 : 32'(settle));
    check("enable_cycles", 32'(en), bad ? 32'd0 : 32'(settle));
    check("rsp_valid", 32'(rsp_valid[idx]), 32'd1);
    check("rsp_data", 32'(rsp_data[idx]), 32'(exp));
    check("rsp_zero", 32'(rsp_zero[idx]), (!bad && exp == 8'd0) ? 32'd1 : 32'd0);
    check("rsp_err", 32'(rsp_err[idx]), 32'(bad));
    check("enable_off_in_resp", 32'(alu_enable[idx]), 32'd0);
    check_counts(idx);
    for (int k = 0; k < delay; k++) begin
      tick();
      check("rsp_hold_valid", 32'(rsp_valid[idx]), 32'd1);
      check("rsp_hold_data", 32'(rsp_data[idx]), 32'(exp));
      check("rsp_hold_ready", 32'(cmd_ready[idx]), 32'd0);
      check("rsp_hold_alu_a", 32'(alu_a[idx]), 32'(a));
    end
    rsp_ready[idx] = 1'b1;
    tick();
    rsp_ready[idx] = 1'b0;
    check("rsp_valid_cleared", 32'(rsp_valid[idx]), 32'd0);
    check("ready_after_rsp", 32'(cmd_ready[idx]), 32'd1);
    check("rsp_data_kept", 32'(rsp_data[idx]), 32'(exp));
    check("rsp_err_kept", 32'(rsp_err[idx]), 32'(bad));
    check("operand_hold", 32'(alu_b[idx]), 32'(b));
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i]       = 1'b1;
      cmd_valid[i] = 1'b0;
      cmd_a[i]     = 8'd0;
      cmd_b[i]     = 8'd0;
      cmd_op[i]    = 3'd0;
      rsp_ready[i] = 1'b0;
      done_m[i]    = 0;
      err_m[i]     = 0;
    end
    tick();
    tick();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("reset_ready", 32'(cmd_ready[i]), 32'd1);
      check("reset_rsp_valid", 32'(rsp_valid[i]), 32'd0);
      check("reset_enable", 32'(alu_enable[i]), 32'd0);
      check("reset_alu_a", 32'(alu_a[i]), 32'd0);
      check("reset_rsp_data", 32'(rsp_data[i]), 32'd0);
      check_counts(i);
    end

    // Directed plan on the settle-1 instance.
    do_cmd(0, 8'h7F, 8'h01, 3'd0, 0, 1'b0, 8'h00, 8'h00, 3'd0);
    do_cmd(0, 8'h05, 8'h05, 3'd1, 0, 1'b0, 8'h00, 8'h00, 3'd0);
    do_cmd(0, 8'h10, 8'h10, 3'd2, 0, 1'b0, 8'h00, 8'h00, 3'd0);
    do_cmd(0, 8'h10, 8'h00, 3'd3, 0, 1'b0, 8'h00, 8'h00, 3'd0);
    do_cmd(0, 8'h22, 8'h33, 3'd7, 0, 1'b0, 8'h00, 8'h00, 3'd0);
    do_cmd(0, 8'hF0, 8'h3C, 3'd4, 5, 1'b1, 8'h12, 8'h34, 3'd5);
    do_cmd(0, 8'h12, 8'h34, 3'd5, 0, 1'b0, 8'h00, 8'h00, 3'd0);
    do_cmd(0, 8'h64, 8'h07, 3'd3, 1, 1'b0, 8'h00, 8'h00, 3'd0);

    // Settle-4 instance.
    do_cmd(1, 8'hAA, 8'hFF, 3'd6, 1, 1'b0, 8'h00, 8'h00, 3'd0);

    // Reset while in DRIVE discards the command.
    cmd_a[1]     = 8'h11;
    cmd_b[1]     = 8'h22;
    cmd_op[1]    = 3'd0;
    cmd_valid[1] = 1'b1;
    tick();
    cmd_valid[1] = 1'b0;
    tick();
    check("mid_drive_enable", 32'(alu_enable[1]), 32'd1);
    rst[1] = 1'b1;
    tick();
    rst[1]    = 1'b0;
    done_m[1] = 0;
    err_m[1]  = 0;
    check("rst_mid_enable", 32'(alu_enable[1]), 32'd0);
    check("rst_mid_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    check("rst_mid_ready", 32'(cmd_ready[1]), 32'd1);
    check("rst_mid_alu_a", 32'(alu_a[1]), 32'd0);
    check_counts(1);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("rst_no_response", 32'(rsp_valid[1]), 32'd0);
    end

    // Random commands on both instances.
    for (int k = 0; k < 25; k++) begin
      for (int i = 0; i < 2; i++) begin
        logic [7:0] ra, rb;
        logic [2:0] rop;
        ra  = 8'($urandom);
        rb  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
        rop = 3'($urandom_range(0, 7));
        do_cmd(i, ra, rb, rop, int'($urandom_range(0, 3)), 1'b0, 8'h00, 8'h00, 3'd0);
      end
    end
    check_counts(0);
    check_counts(1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
